// File: rtl/dt_pkg.sv
// Shared constants for the digital-tube scan controller: register map,
// CTRL field positions, reset values and the active-low segment table.
package dt_pkg;

  localparam logic [1:0] DT_ADDR_DATA = 2'd0;
  localparam logic [1:0] DT_ADDR_CTRL = 2'd1;

  localparam int unsigned CTRL_EN_BIT = 0;
  localparam int unsigned CTRL_DP_LSB = 8;
  localparam int unsigned CTRL_DP_MSB = 15;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {a,b,c,d,e,f,g}; dp is appended by the scan controller.
  localparam logic [6:0] SEG_HEX_0 = 7'h01;
  localparam logic [6:0] SEG_HEX_1 = 7'h4F;
  localparam logic [6:0] SEG_HEX_2 = 7'h12;
  localparam logic [6:0] SEG_HEX_3 = 7'h06;
  localparam logic [6:0] SEG_HEX_4 = 7'h4C;
  localparam logic [6:0] SEG_HEX_5 = 7'h24;
  localparam logic [6:0] SEG_HEX_6 = 7'h20;
  localparam logic [6:0] SEG_HEX_7 = 7'h0F;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h04;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h60;
  localparam logic [6:0] SEG_HEX_C = 7'h31;
  localparam logic [6:0] SEG_HEX_D = 7'h42;
  localparam logic [6:0] SEG_HEX_E = 7'h30;
  localparam logic [6:0] SEG_HEX_F = 7'h38;

endpackage

// File: rtl/dt_hex_seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module dt_hex_seg
  import dt_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    seg7 = SEG_HEX_0;
    case (nibble)
      4'h0: seg7 = SEG_HEX_0;
      4'h1: seg7 = SEG_HEX_1;
      4'h2: seg7 = SEG_HEX_2;
      4'h3: seg7 = SEG_HEX_3;
      4'h4: seg7 = SEG_HEX_4;
      4'h5: seg7 = SEG_HEX_5;
      4'h6: seg7 = SEG_HEX_6;
      4'h7: seg7 = SEG_HEX_7;
      4'h8: seg7 = SEG_HEX_8;
      4'h9: seg7 = SEG_HEX_9;
      4'hA: seg7 = SEG_HEX_A;
      4'hB: seg7 = SEG_HEX_B;
      4'hC: seg7 = SEG_HEX_C;
      4'hD: seg7 = SEG_HEX_D;
      4'hE: seg7 = SEG_HEX_E;
      default: seg7 = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/dt_scan_ctrl.sv
// Memory-mapped 8-digit common-anode 7-segment scan controller.
// Optional build macro: DT_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always shown).
module dt_scan_ctrl
  import dt_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic [7:0]  digit_sel,
  output logic [7:0]  seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

  logic [31:0]      data_q;
  logic             en_q;
  logic [7:0]       dp_q;
  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] idx;

  logic             wr_data;
  logic             wr_ctrl;
  logic             en_next;
  logic             scan_run;
  logic [3:0]       nibble;
  logic [6:0]       seg7;
  logic             lz_blank;

  assign wr_data = we && (addr == DT_ADDR_DATA);
  assign wr_ctrl = we && (addr == DT_ADDR_CTRL);

  // A CTRL write that clears EN on this edge also stops the scan on this edge.
  assign en_next  = (wr_ctrl && be[0]) ? wdata[CTRL_EN_BIT] : en_q;
  assign scan_run = en_q && en_next;

  assign nibble = data_q[{idx, 2'b00} +: 4];

  dt_hex_seg u_hex_seg (
    .nibble (nibble),
    .seg7   (seg7)
  );

  // Leading-zero detection: current nibble and every higher one are zero.
`ifdef DT_LEADING_ZERO_BLANK_EN
  assign lz_blank = (idx != '0) && ((data_q >> {idx, 2'b00}) == '0);
`else
  assign lz_blank = 1'b0;
`endif

  // Byte-enabled DATA and CTRL register writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      en_q   <= CTRL_RESET[CTRL_EN_BIT];
      dp_q   <= CTRL_RESET[CTRL_DP_MSB:CTRL_DP_LSB];
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_data && be[i]) data_q[8*i +: 8] <= wdata[8*i +: 8];
      end
      if (wr_ctrl && be[0]) en_q <= wdata[CTRL_EN_BIT];
      if (wr_ctrl && be[1]) dp_q <= wdata[CTRL_DP_MSB:CTRL_DP_LSB];
    end
  end

  // Scan timer and digit pointer; both hold while the scan is stopped.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_run) begin
      if (scan_cnt == CNT_TC) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_TOP) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Registered tube drive, digit select and segments updated together.
  always_ff @(posedge clk) begin
    if (reset || !en_q) begin
      digit_sel <= '1;
      seg       <= SEG_BLANK;
    end else begin
      digit_sel <= ~(8'b1 << idx);
      seg       <= lz_blank ? SEG_BLANK : {~dp_q[idx], seg7};
    end
  end

  // Side-effect-free register read.
  always_comb begin
    rdata = '0;
    case (addr)
      DT_ADDR_DATA: rdata = data_q;
      DT_ADDR_CTRL: rdata = {16'h0, dp_q, 7'h0, en_q};
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dt_scan_ctrl.sv
// Self-checking bench for dt_scan_ctrl with a cycle-level behavioural model.
module tb_dt_scan_ctrl;

  localparam int SDIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic [7:0]  digit_sel;
  logic [7:0]  seg;

  dt_scan_ctrl #(.SCAN_DIV(SDIV), .NUM_DIGITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .rdata     (rdata),
    .digit_sel (digit_sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  // Decode table with dp off, straight from the display code list.
  logic [7:0] hex_tbl [16] = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                               8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8};

  // Model state
  logic [31:0] m_data;
  logic        m_en;
  logic [7:0]  m_dp;
  int          m_cnt;
  int          m_idx;
  logic [7:0]  e_sel;
  logic [7:0]  e_seg;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge();
    logic [3:0] nib;
    logic       blank;
    logic       new_en;
    if (reset) begin
      m_data = 32'h0; m_en = 1'b1; m_dp = 8'h0; m_cnt = 0; m_idx = 0;
      e_sel = 8'hFF; e_seg = 8'hFF;
    end else begin
      if (!m_en) begin
        e_sel = 8'hFF; e_seg = 8'hFF;
      end else begin
        e_sel = ~(8'h01 << m_idx);
        nib = 4'((m_data >> (4 * m_idx)) & 32'hF);
        blank = 1'b0;
`ifdef DT_LEADING_ZERO_BLANK_EN
        blank = (m_idx != 0) && ((m_data >> (4 * m_idx)) == 32'h0);
`endif
        e_seg = blank ? 8'hFF : {~m_dp[m_idx], hex_tbl[nib][6:0]};
      end
      new_en = (we && addr == 2'd1 && be[0]) ? wdata[0] : m_en;
      if (m_en && new_en) begin
        if (m_cnt == SDIV - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % 8;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (we && addr == 2'd0) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_data[8*i +: 8] = wdata[8*i +: 8];
      end
      if (we && addr == 2'd1) begin
        if (be[0]) m_en = wdata[0];
        if (be[1]) m_dp = wdata[15:8];
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return {16'h0, m_dp, 7'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("digit_sel", {24'h0, digit_sel}, {24'h0, e_sel});
    chk("seg", {24'h0, seg}, {24'h0, e_seg});
    chk("rdata", rdata, model_read(addr));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; addr = a; wdata = d; be = b;
    tick();
    we = 1'b0; be = 4'h0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'h0; be = 4'h0;
    m_data = 32'h0; m_en = 1'b1; m_dp = 8'h0; m_cnt = 0; m_idx = 0;
    e_sel = 8'hFF; e_seg = 8'hFF;

    // Reset state
    ticks(2);
    chk("reset_sel", {24'h0, digit_sel}, 32'hFF);
    chk("reset_seg", {24'h0, seg}, 32'hFF);
    reset = 1'b0;

    // Idle scan: zeros on every digit
    tick();
    chk("first_sel", {24'h0, digit_sel}, 32'hFE);
    chk("first_seg", {24'h0, seg}, 32'h81);
    ticks(40);

    // Full hex pattern
    bus_write(2'd0, 32'h89AB_CDEF, 4'hF);
    ticks(34);

    // Byte-masked write from cleared DATA
    reset = 1'b1; tick(); reset = 1'b0;
    bus_write(2'd0, 32'h1234_5678, 4'b0001);
    addr = 2'd0; tick();
    chk("masked_rd", rdata, 32'h0000_0078);

    // Stop and resume the scan
    bus_write(2'd1, 32'h0000_0300, 4'hF);
    ticks(10);
    chk("frozen_sel", {24'h0, digit_sel}, 32'hFF);
    bus_write(2'd1, 32'h0000_0301, 4'hF);
    ticks(20);

    // Clear EN exactly on the terminal count, then resume
    guard = 0;
    while (m_cnt != SDIV - 1 && guard < 20) begin tick(); guard++; end
    chk("tc_reached", guard < 20 ? 32'h1 : 32'h0, 32'h1);
    bus_write(2'd1, 32'h0000_0000, 4'h1);
    ticks(5);
    bus_write(2'd1, 32'h0000_0001, 4'h1);
    ticks(12);

    // DATA write on the same edge as the 7->0 wrap
    guard = 0;
    while (!(m_cnt == SDIV - 1 && m_idx == 7) && guard < 60) begin tick(); guard++; end
    chk("wrap_reached", guard < 60 ? 32'h1 : 32'h0, 32'h1);
    bus_write(2'd0, 32'hFEDC_BA90, 4'hF);
    ticks(6);

    // Decimal point on digit 0, DATA=0, then reset mid-scan
    bus_write(2'd1, 32'h0000_0101, 4'hF);
    bus_write(2'd0, 32'h0000_0000, 4'hF);
    ticks(34);
    addr = 2'd1; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_sel", {24'h0, digit_sel}, 32'hFF);
    chk("midrst_seg", {24'h0, seg}, 32'hFF);
    chk("midrst_ctrl", rdata, 32'h0000_0001);

    // Leading-zero patterns (blanked only in the optional build)
    bus_write(2'd0, 32'h0000_00A5, 4'hF);
    ticks(34);
    bus_write(2'd0, 32'h0000_0000, 4'hF);
    ticks(34);

    // Randomized bus traffic
    for (int i = 0; i < 600; i++) begin
      we    = ($urandom_range(0, 9) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom();
      if ($urandom_range(0, 3) != 0) wdata[0] = 1'b1;
      be    = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    we = 1'b0; reset = 1'b0;
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
